// File: rtl/winograd_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : winograd_tile_sequencer
// Function : Engine-side start/done responder for the Winograd path. Latches
//            the layer tile geometry on start, walks every (row, col,
//            channel-group) tile over a valid/ready request channel, counts
//            completions and pulses done once all issued tiles have returned.
// Revision : 1.0 - initial release
// ============================================================================
module winograd_tile_sequencer #(
    parameter int ROW_W     = 8,
    parameter int COL_W     = 8,
    parameter int CHG_W     = 6,
    parameter int MAX_OUTST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] cfg_rows,
    input  logic [COL_W-1:0] cfg_cols,
    input  logic [CHG_W-1:0] cfg_chg,
    output logic             tile_req,
    input  logic             tile_ack,
    output logic [ROW_W-1:0] tile_row,
    output logic [COL_W-1:0] tile_col,
    output logic [CHG_W-1:0] tile_chg,
    output logic             tile_last,
    input  logic             res_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int               OUT_W       = $clog2(MAX_OUTST + 1);
    localparam logic [OUT_W-1:0] c_max_outst = OUT_W'(MAX_OUTST);
    localparam logic [OUT_W-1:0] c_outst_one = OUT_W'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [ROW_W-1:0] r_cfg_rows;
    logic [COL_W-1:0] r_cfg_cols;
    logic [CHG_W-1:0] r_cfg_chg;

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [CHG_W-1:0] r_chg;
    logic             r_last;
    logic [OUT_W-1:0] r_outst;
    logic             r_req;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_xfer;
    logic             w_start_acc;
    logic             w_cfg_zero;
    logic             w_row_end;
    logic             w_col_end;
    logic             w_chg_end;
    logic             w_final;
    logic             w_res_bad;
    logic             w_res_ok;
    logic [OUT_W-1:0] w_next_outst;
    logic [ROW_W-1:0] w_next_row;
    logic [COL_W-1:0] w_next_col;
    logic [CHG_W-1:0] w_next_chg;
    logic [CHG_W-1:0] w_next_cfg_chg;
    logic             w_next_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, tile-walk and outstanding-count decode.
    always_comb begin
        w_next_state   = r_state;
        w_xfer         = r_req & tile_ack;
        w_start_acc    = (r_state == c_st_idle) & start;
        w_cfg_zero     = (cfg_rows == '0) | (cfg_cols == '0) | (cfg_chg == '0);
        w_row_end      = (r_row == r_cfg_rows - ROW_W'(1));
        w_col_end      = (r_col == r_cfg_cols - COL_W'(1));
        w_chg_end      = (r_chg == r_cfg_chg - CHG_W'(1));
        w_final        = w_row_end & w_col_end & w_chg_end;
        // A result with nothing in flight (and no tile entering flight this
        // cycle) is spurious: flag it and keep the counter from wrapping.
        w_res_bad      = res_valid & (r_outst == '0) & ~w_xfer;
        w_res_ok       = res_valid & ~w_res_bad;

        w_next_outst   = r_outst;
        if (w_start_acc) begin
            w_next_outst = '0;
        end else if (w_xfer & ~w_res_ok) begin
            w_next_outst = r_outst + c_outst_one;
        end else if (w_res_ok & ~w_xfer) begin
            w_next_outst = r_outst - c_outst_one;
        end

        // Channel group is innermost, then column, then row.
        w_next_row     = r_row;
        w_next_col     = r_col;
        w_next_chg     = r_chg;
        if (w_start_acc) begin
            w_next_row = '0;
            w_next_col = '0;
            w_next_chg = '0;
        end else if (w_xfer) begin
            if (w_chg_end) begin
                w_next_chg = '0;
                if (w_col_end) begin
                    w_next_col = '0;
                    w_next_row = w_row_end ? '0 : r_row + ROW_W'(1);
                end else begin
                    w_next_col = r_col + COL_W'(1);
                end
            end else begin
                w_next_chg = r_chg + CHG_W'(1);
            end
        end

        // tile_last is registered, so it is derived from the next index and
        // the config that will be in force next cycle.
        w_next_cfg_chg = w_start_acc ? cfg_chg : r_cfg_chg;
        w_next_last    = (w_next_chg == w_next_cfg_chg - CHG_W'(1));

        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_next_state = w_cfg_zero ? c_st_done : c_st_issue;
                end
            end
            c_st_issue: begin
                if (w_xfer & w_final) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                if (r_outst == '0) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Config latch, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_rows <= '0;
            r_cfg_cols <= '0;
            r_cfg_chg  <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_chg      <= '0;
            r_last     <= 1'b0;
            r_outst    <= '0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_cfg_rows <= cfg_rows;
                r_cfg_cols <= cfg_cols;
                r_cfg_chg  <= cfg_chg;
            end
            r_row   <= w_next_row;
            r_col   <= w_next_col;
            r_chg   <= w_next_chg;
            r_last  <= w_next_last;
            r_outst <= w_next_outst;
            r_req   <= (w_next_state == c_st_issue) && (w_next_outst < c_max_outst);
            r_busy  <= (w_next_state != c_st_idle);
            r_done  <= (w_next_state == c_st_done);
            if (w_start_acc & ~w_cfg_zero) begin
                r_err <= 1'b0;
            end else if ((w_start_acc & w_cfg_zero) | w_res_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign tile_req  = r_req;
    assign tile_row  = r_row;
    assign tile_col  = r_col;
    assign tile_chg  = r_chg;
    assign tile_last = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_winograd_tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_winograd_tile_sequencer
// Function : Self-checking bench for winograd_tile_sequencer. Expected tiles
//            are queued when a run is started and compared against the
//            transfers captured from the request channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_winograd_tile_sequencer;

    localparam int ROW_W     = 8;
    localparam int COL_W     = 8;
    localparam int CHG_W     = 6;
    localparam int MAX_OUTST = 4;
    localparam int OBS_DEPTH = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [ROW_W-1:0] cfg_rows = '0;
    logic [COL_W-1:0] cfg_cols = '0;
    logic [CHG_W-1:0] cfg_chg = '0;
    logic             tile_ack = 1'b0;
    logic             res_valid = 1'b0;
    logic             tile_req;
    logic [ROW_W-1:0] tile_row;
    logic [COL_W-1:0] tile_col;
    logic [CHG_W-1:0] tile_chg;
    logic             tile_last;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    winograd_tile_sequencer #(
        .ROW_W     (ROW_W),
        .COL_W     (COL_W),
        .CHG_W     (CHG_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_rows  (cfg_rows),
        .cfg_cols  (cfg_cols),
        .cfg_chg   (cfg_chg),
        .tile_req  (tile_req),
        .tile_ack  (tile_ack),
        .tile_row  (tile_row),
        .tile_col  (tile_col),
        .tile_chg  (tile_chg),
        .tile_last (tile_last),
        .res_valid (res_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [CHG_W-1:0] chg;
        logic             last;
    } tile_t;

    tile_t sb [$];
    tile_t obs [OBS_DEPTH];
    int    n_xfer = 0;
    logic  xfer_seen = 1'b0;
    int    rd_ptr = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    // Capture each request-channel transfer mid-cycle.
    always @(negedge clk) begin
        xfer_seen = 1'b0;
        if (!rst && tile_req && tile_ack) begin
            xfer_seen = 1'b1;
            if (n_xfer < OBS_DEPTH) obs[n_xfer] = tile_t'({tile_row, tile_col, tile_chg, tile_last});
            n_xfer = n_xfer + 1;
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want finish");
        $fatal(1, "watchdog");
    end

    task automatic push_tiles(input int r, input int c, input int g);
        tile_t t;
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                for (int k = 0; k < g; k++) begin
                    t.row  = ROW_W'(i);
                    t.col  = COL_W'(j);
                    t.chg  = CHG_W'(k);
                    t.last = (k == g - 1);
                    sb.push_back(t);
                end
    endtask

    task automatic pulse_start(input int r, input int c, input int g);
        @(posedge clk); #1;
        start    = 1'b1;
        cfg_rows = ROW_W'(r);
        cfg_cols = COL_W'(c);
        cfg_chg  = CHG_W'(g);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (tile_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", tile_req); end
        n_checks++; if ({tile_row, tile_col, tile_chg} !== '0) begin n_errors++; $display("FAIL reset_idx: got %0d/%0d/%0d want 0/0/0", tile_row, tile_col, tile_chg); end
        n_checks++; if (tile_last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b want 0", tile_last); end
        n_checks++; if ({busy, done, err} !== 3'b000) begin n_errors++; $display("FAIL reset_status: got busy/done/err=%b want 000", {busy, done, err}); end
        rst = 1'b0;
    endtask

    task automatic test_minimal;
        tile_t got, want;
        bit    done_seen;
        push_tiles(2, 2, 1);
        tile_ack  = 1'b1;
        res_valid = 1'b0;
        pulse_start(2, 2, 1);
        n_checks++; if ({busy, tile_req} !== 2'b11) begin n_errors++; $display("FAIL min_start_latency: got busy/req=%b want 11", {busy, tile_req}); end
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 64 && !done_seen; cyc++) begin
            @(posedge clk); #1;
            res_valid = xfer_seen;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL min_err: got %b want 0", err); end
            end
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL min_busy_span: got %b want 1 at cycle %0d", busy, cyc); end
        end
        n_checks++; if (!done_seen) begin n_errors++; $display("FAIL min_done_timeout: got no done want done"); end
        @(posedge clk); #1;
        res_valid = 1'b0;
        n_checks++; if ({done, busy} !== 2'b00) begin n_errors++; $display("FAIL min_done_width: got done/busy=%b want 00", {done, busy}); end
        while (rd_ptr < n_xfer) begin
            got = obs[rd_ptr]; rd_ptr++;
            n_checks++;
            if (sb.size() == 0) begin n_errors++; $display("FAIL min_tile: got extra r%0d c%0d g%0d want none", got.row, got.col, got.chg); end
            else begin
                want = sb.pop_front();
                if (got !== want) begin n_errors++; $display("FAIL min_tile: got r%0d c%0d g%0d l%b want r%0d c%0d g%0d l%b", got.row, got.col, got.chg, got.last, want.row, want.col, want.chg, want.last); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL min_missing: got %0d tiles unissued want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_stall;
        tile_t got, want;
        bit    done_seen;
        int    base;
        base = n_xfer;
        push_tiles(1, 1, 8);
        tile_ack  = 1'b1;
        res_valid = 1'b0;
        pulse_start(1, 1, 8);
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if ((n_xfer - base) != 4 || tile_req !== 1'b0) begin n_errors++; $display("FAIL stall_limit: got %0d xfers req=%b want 4 req=0", n_xfer - base, tile_req); end
        res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if ((n_xfer - base) != 5 || tile_req !== 1'b0) begin n_errors++; $display("FAIL stall_one_more: got %0d xfers req=%b want 5 req=0", n_xfer - base, tile_req); end
        // Free a slot, then overlap a result with the next transfer.
        res_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (tile_req !== 1'b1) begin n_errors++; $display("FAIL stall_release: got req=%b want 1", tile_req); end
        @(posedge clk); #1;
        res_valid = 1'b0;
        n_checks++; if (tile_req !== 1'b1) begin n_errors++; $display("FAIL stall_simul_count: got req=%b want 1", tile_req); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if ((n_xfer - base) != 7 || tile_req !== 1'b0) begin n_errors++; $display("FAIL stall_simul_total: got %0d xfers req=%b want 7 req=0", n_xfer - base, tile_req); end
        res_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        res_valid = 1'b0;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 20 && !done_seen; cyc++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL stall_err: got %b want 0", err); end
            end
        end
        n_checks++; if (!done_seen) begin n_errors++; $display("FAIL stall_done_timeout: got no done want done"); end
        while (rd_ptr < n_xfer) begin
            got = obs[rd_ptr]; rd_ptr++;
            n_checks++;
            if (sb.size() == 0) begin n_errors++; $display("FAIL stall_tile: got extra r%0d c%0d g%0d want none", got.row, got.col, got.chg); end
            else begin
                want = sb.pop_front();
                if (got !== want) begin n_errors++; $display("FAIL stall_tile: got r%0d c%0d g%0d l%b want r%0d c%0d g%0d l%b", got.row, got.col, got.chg, got.last, want.row, want.col, want.chg, want.last); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL stall_missing: got %0d tiles unissued want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_backpressure;
        tile_t            got, want;
        bit               done_seen;
        logic             prev_req, prev_ack;
        logic [ROW_W-1:0] prev_row;
        logic [COL_W-1:0] prev_col;
        logic [CHG_W-1:0] prev_chg;
        int               base;
        base = n_xfer;
        push_tiles(1, 2, 3);
        tile_ack  = 1'b0;
        res_valid = 1'b0;
        pulse_start(1, 2, 3);
        tile_ack  = 1'($urandom_range(0, 1));
        prev_req  = tile_req; prev_ack = tile_ack;
        prev_row  = tile_row; prev_col = tile_col; prev_chg = tile_chg;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            @(posedge clk); #1;
            res_valid = xfer_seen;
            if (prev_req && !prev_ack) begin
                n_checks++;
                if (tile_req !== 1'b1 || tile_row !== prev_row || tile_col !== prev_col || tile_chg !== prev_chg) begin
                    n_errors++; $display("FAIL bp_stable: got req=%b %0d/%0d/%0d want 1 %0d/%0d/%0d", tile_req, tile_row, tile_col, tile_chg, prev_row, prev_col, prev_chg);
                end
            end
            if (tile_req === 1'b1) begin
                n_checks++; if (tile_last !== (tile_chg == CHG_W'(2))) begin n_errors++; $display("FAIL bp_last: got %b at chg %0d want %b", tile_last, tile_chg, (tile_chg == CHG_W'(2))); end
            end
            if (done === 1'b1) done_seen = 1'b1;
            tile_ack = 1'($urandom_range(0, 1));
            prev_req = tile_req; prev_ack = tile_ack;
            prev_row = tile_row; prev_col = tile_col; prev_chg = tile_chg;
        end
        res_valid = 1'b0;
        n_checks++; if (!done_seen) begin n_errors++; $display("FAIL bp_done_timeout: got no done want done"); end
        n_checks++; if ((n_xfer - base) != 6) begin n_errors++; $display("FAIL bp_count: got %0d xfers want 6", n_xfer - base); end
        while (rd_ptr < n_xfer) begin
            got = obs[rd_ptr]; rd_ptr++;
            n_checks++;
            if (sb.size() == 0) begin n_errors++; $display("FAIL bp_tile: got extra r%0d c%0d g%0d want none", got.row, got.col, got.chg); end
            else begin
                want = sb.pop_front();
                if (got !== want) begin n_errors++; $display("FAIL bp_tile: got r%0d c%0d g%0d l%b want r%0d c%0d g%0d l%b", got.row, got.col, got.chg, got.last, want.row, want.col, want.chg, want.last); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL bp_missing: got %0d tiles unissued want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_zero_cfg;
        tile_t got, want;
        bit    done_seen;
        tile_ack  = 1'b1;
        res_valid = 1'b0;
        pulse_start(3, 0, 2);
        n_checks++; if ({done, err, busy, tile_req} !== 4'b1110) begin n_errors++; $display("FAIL zero_first: got done/err/busy/req=%b want 1110", {done, err, busy, tile_req}); end
        @(posedge clk); #1;
        n_checks++; if ({done, err, busy, tile_req} !== 4'b0100) begin n_errors++; $display("FAIL zero_after: got done/err/busy/req=%b want 0100", {done, err, busy, tile_req}); end
        push_tiles(1, 1, 1);
        pulse_start(1, 1, 1);
        n_checks++; if ({err, tile_req, tile_last} !== 3'b011) begin n_errors++; $display("FAIL zero_clear_err: got err/req/last=%b want 011", {err, tile_req, tile_last}); end
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 20 && !done_seen; cyc++) begin
            @(posedge clk); #1;
            res_valid = xfer_seen;
            if (done === 1'b1) done_seen = 1'b1;
        end
        res_valid = 1'b0;
        n_checks++; if (!done_seen || err !== 1'b0) begin n_errors++; $display("FAIL zero_rerun: got done_seen=%b err=%b want 1 0", done_seen, err); end
        while (rd_ptr < n_xfer) begin
            got = obs[rd_ptr]; rd_ptr++;
            n_checks++;
            if (sb.size() == 0) begin n_errors++; $display("FAIL zero_tile: got extra r%0d c%0d g%0d want none", got.row, got.col, got.chg); end
            else begin
                want = sb.pop_front();
                if (got !== want) begin n_errors++; $display("FAIL zero_tile: got r%0d c%0d g%0d l%b want r%0d c%0d g%0d l%b", got.row, got.col, got.chg, got.last, want.row, want.col, want.chg, want.last); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL zero_missing: got %0d tiles unissued want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_start_busy;
        tile_t got, want;
        bit    done_seen;
        push_tiles(2, 1, 2);
        tile_ack  = 1'b1;
        res_valid = 1'b0;
        pulse_start(2, 1, 2);
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            @(posedge clk); #1;
            res_valid = xfer_seen;
            start     = (cyc == 0);
            if (cyc == 0) begin
                cfg_rows = ROW_W'(3); cfg_cols = COL_W'(3); cfg_chg = CHG_W'(3);
            end
            if (done === 1'b1) done_seen = 1'b1;
        end
        start     = 1'b0;
        res_valid = 1'b0;
        n_checks++; if (!done_seen || err !== 1'b0) begin n_errors++; $display("FAIL busy_done: got done_seen=%b err=%b want 1 0", done_seen, err); end
        while (rd_ptr < n_xfer) begin
            got = obs[rd_ptr]; rd_ptr++;
            n_checks++;
            if (sb.size() == 0) begin n_errors++; $display("FAIL busy_tile: got extra r%0d c%0d g%0d want none", got.row, got.col, got.chg); end
            else begin
                want = sb.pop_front();
                if (got !== want) begin n_errors++; $display("FAIL busy_tile: got r%0d c%0d g%0d l%b want r%0d c%0d g%0d l%b", got.row, got.col, got.chg, got.last, want.row, want.col, want.chg, want.last); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL busy_missing: got %0d tiles unissued want 0", sb.size()); sb.delete(); end
        @(posedge clk); #1;
        res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        n_checks++; if ({err, busy} !== 2'b10) begin n_errors++; $display("FAIL busy_spurious_res: got err/busy=%b want 10", {err, busy}); end
    endtask

    task automatic test_reset_mid;
        tile_t got, want;
        bit    done_seen;
        int    base;
        base = n_xfer;
        push_tiles(1, 1, 8);
        tile_ack  = 1'b1;
        res_valid = 1'b0;
        pulse_start(1, 1, 8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst      = 1'b1;
        tile_ack = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({tile_req, tile_last, busy, done, err} !== 5'b00000) begin n_errors++; $display("FAIL rstmid_flags: got req/last/busy/done/err=%b want 00000", {tile_req, tile_last, busy, done, err}); end
        n_checks++; if ({tile_row, tile_col, tile_chg} !== '0) begin n_errors++; $display("FAIL rstmid_idx: got %0d/%0d/%0d want 0/0/0", tile_row, tile_col, tile_chg); end
        rst = 1'b0;
        n_checks++; if ((n_xfer - base) != 2) begin n_errors++; $display("FAIL rstmid_count: got %0d xfers want 2", n_xfer - base); end
        while (rd_ptr < n_xfer) begin
            got = obs[rd_ptr]; rd_ptr++;
            n_checks++;
            if (sb.size() == 0) begin n_errors++; $display("FAIL rstmid_tile: got extra r%0d c%0d g%0d want none", got.row, got.col, got.chg); end
            else begin
                want = sb.pop_front();
                if (got !== want) begin n_errors++; $display("FAIL rstmid_tile: got r%0d c%0d g%0d l%b want r%0d c%0d g%0d l%b", got.row, got.col, got.chg, got.last, want.row, want.col, want.chg, want.last); end
            end
        end
        sb.delete();
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            n_checks++; if ({done, busy} !== 2'b00) begin n_errors++; $display("FAIL rstmid_no_done: got done/busy=%b want 00 at cycle %0d", {done, busy}, cyc); end
        end
        push_tiles(2, 2, 1);
        tile_ack = 1'b1;
        pulse_start(2, 2, 1);
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            @(posedge clk); #1;
            res_valid = xfer_seen;
            if (done === 1'b1) done_seen = 1'b1;
        end
        res_valid = 1'b0;
        n_checks++; if (!done_seen || err !== 1'b0) begin n_errors++; $display("FAIL rstmid_rerun: got done_seen=%b err=%b want 1 0", done_seen, err); end
        while (rd_ptr < n_xfer) begin
            got = obs[rd_ptr]; rd_ptr++;
            n_checks++;
            if (sb.size() == 0) begin n_errors++; $display("FAIL rstmid_rerun_tile: got extra r%0d c%0d g%0d want none", got.row, got.col, got.chg); end
            else begin
                want = sb.pop_front();
                if (got !== want) begin n_errors++; $display("FAIL rstmid_rerun_tile: got r%0d c%0d g%0d l%b want r%0d c%0d g%0d l%b", got.row, got.col, got.chg, got.last, want.row, want.col, want.chg, want.last); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL rstmid_missing: got %0d tiles unissued want 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_minimal();
        test_stall();
        test_backpressure();
        test_zero_cfg();
        test_start_busy();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
